// File: rtl/alucodes.sv
// ALU function codes shared by the decoder and the datapath.
package alucodes;

    localparam logic [2:0] RA   = 3'b000;
    localparam logic [2:0] RB   = 3'b001;
    localparam logic [2:0] RADD = 3'b010;
    localparam logic [2:0] RSUB = 3'b011;

endpackage

// File: rtl/decoder_pkg.sv
// Opcode/state enums, instruction field positions and the opcode decode table.
package decoder_pkg;

    import alucodes::*;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_ADDI = 4'b0010,
        OP_SUB  = 4'b0011,
        OP_SUBI = 4'b0100,
        OP_MOV  = 4'b0101,
        OP_LDI  = 4'b0110,
        OP_BEQ  = 4'b1000,
        OP_BNE  = 4'b1001,
        OP_BCS  = 4'b1010,
        OP_HALT = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXEC   = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef struct packed {
        logic [2:0] alu_func;
        logic       b_imm_sel;
        logic       reg_we;
        logic       is_arith;
        logic       is_branch;
        logic       is_halt;
        logic       legal;
    } decode_t;

    // Unknown opcodes (and branches when disabled) fall through as NOP with legal=0.
    function automatic decode_t decode_op(input logic [3:0] op, input logic branch_en);
        decode_t d;
        d          = '0;
        d.alu_func = RA;
        d.legal    = 1'b1;
        case (op)
            OP_NOP:  ;
            OP_ADD:  begin d.alu_func = RADD; d.reg_we = 1'b1; d.is_arith = 1'b1; end
            OP_ADDI: begin d.alu_func = RADD; d.b_imm_sel = 1'b1; d.reg_we = 1'b1; d.is_arith = 1'b1; end
            OP_SUB:  begin d.alu_func = RSUB; d.reg_we = 1'b1; d.is_arith = 1'b1; end
            OP_SUBI: begin d.alu_func = RSUB; d.b_imm_sel = 1'b1; d.reg_we = 1'b1; d.is_arith = 1'b1; end
            OP_MOV:  begin d.alu_func = RB; d.reg_we = 1'b1; end
            OP_LDI:  begin d.alu_func = RB; d.b_imm_sel = 1'b1; d.reg_we = 1'b1; end
            OP_BEQ, OP_BNE, OP_BCS: begin
                d.is_branch = branch_en;
                d.legal     = branch_en;
            end
            OP_HALT: d.is_halt = 1'b1;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition: BEQ on Z, BNE on !Z, BCS on C.
module branch_cond
    import decoder_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] flags,
    output logic       taken
);

    logic [1:0] w_unused_flags;
    assign w_unused_flags = {flags[FLAG_V], flags[FLAG_N]};

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = flags[FLAG_Z];
            OP_BNE:  taken = ~flags[FLAG_Z];
            OP_BCS:  taken = flags[FLAG_C];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_decoder.sv
// Two-cycle instruction decoder (IDLE/EXEC/HALTED) with registered control outputs.
// Define BRANCH_EN to enable BEQ/BNE/BCS; otherwise they decode as illegal and pc_load is 0.
module instr_decoder
    import alucodes::*;
    import decoder_pkg::*;
#(
    parameter int n  = 8,
    parameter int IW = 16
)
(
    input  logic          clk,
    input  logic          nReset,
    input  logic [IW-1:0] instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    alu_flags,
    output logic [2:0]    alu_func,
    output logic          b_imm_sel,
    output logic [n-1:0]  imm,
    output logic [2:0]    rd_addr,
    output logic [2:0]    rs_addr,
    output logic          reg_we,
    output logic          pc_incr,
    output logic          pc_load,
    output logic [3:0]    flags_q,
    output logic          halted,
    output logic          illegal
);

`ifdef BRANCH_EN
    localparam logic BRANCH_EN_C = 1'b1;
`else
    localparam logic BRANCH_EN_C = 1'b0;
`endif

    state_e        r_state;
    logic [2:0]    r_alu_func;
    logic          r_b_imm_sel;
    logic [n-1:0]  r_imm;
    logic [2:0]    r_rd_addr;
    logic [2:0]    r_rs_addr;
    logic          r_reg_we;
    logic          r_pc_incr;
    logic [3:0]    r_flags;
    logic          r_halted;
    logic          r_illegal;
    logic          r_is_arith;
    logic          r_is_halt;

    decode_t       w_dec;
    logic          w_branch_taken;

    assign w_dec = decode_op(instr[OP_MSB:OP_LSB], BRANCH_EN_C);

`ifdef BRANCH_EN
    logic w_taken;
    logic r_pc_load;

    // Evaluated against flags_q before any EXEC-end capture, i.e. flags at EXEC start.
    branch_cond u_branch_cond (
        .opcode (instr[OP_MSB:OP_LSB]),
        .flags  (r_flags),
        .taken  (w_taken)
    );

    assign w_branch_taken = w_dec.is_branch & w_taken;
    assign pc_load        = r_pc_load;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_pc_load <= 1'b0;
        end else if (r_state == ST_IDLE && instr_valid) begin
            r_pc_load <= w_branch_taken;
        end else begin
            r_pc_load <= 1'b0;
        end
    end
`else
    assign w_branch_taken = w_dec.is_branch;
    assign pc_load        = 1'b0;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state     <= ST_IDLE;
            r_alu_func  <= RA;
            r_b_imm_sel <= 1'b0;
            r_imm       <= '0;
            r_rd_addr   <= '0;
            r_rs_addr   <= '0;
            r_reg_we    <= 1'b0;
            r_pc_incr   <= 1'b0;
            r_flags     <= '0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            r_is_arith  <= 1'b0;
            r_is_halt   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_state     <= ST_EXEC;
                        r_alu_func  <= w_dec.alu_func;
                        r_b_imm_sel <= w_dec.b_imm_sel;
                        r_imm       <= n'(instr[IMM_MSB:IMM_LSB]);
                        r_rd_addr   <= instr[RD_MSB:RD_LSB];
                        r_rs_addr   <= instr[RS_MSB:RS_LSB];
                        r_reg_we    <= w_dec.reg_we;
                        r_pc_incr   <= ~w_branch_taken;
                        r_is_arith  <= w_dec.is_arith;
                        r_is_halt   <= w_dec.is_halt;
                        if (!w_dec.legal) begin
                            r_illegal <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    r_alu_func  <= RA;
                    r_b_imm_sel <= 1'b0;
                    r_reg_we    <= 1'b0;
                    r_pc_incr   <= 1'b0;
                    if (r_is_arith) begin
                        r_flags <= alu_flags;
                    end
                    if (r_is_halt) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign alu_func    = r_alu_func;
    assign b_imm_sel   = r_b_imm_sel;
    assign imm         = r_imm;
    assign rd_addr     = r_rd_addr;
    assign rs_addr     = r_rs_addr;
    assign reg_we      = r_reg_we;
    assign pc_incr     = r_pc_incr;
    assign flags_q     = r_flags;
    assign halted      = r_halted;
    assign illegal     = r_illegal;

endmodule
